// File: rtl/pcm_pkg.sv
// Shared constants and types for the PCM sample scheduler: the clip table,
// the voice count, the default ROM address width and the playback states.
package pcm_pkg;

  localparam int NVOICE     = 4;
  localparam int AW_DEFAULT = 13;

  // Clip start addresses, indexed by voice (v0 relay-on, v1 relay-off, v2, v3)
  localparam logic [NVOICE-1:0][15:0] BASE = {16'h1000, 16'h0800, 16'h0400, 16'h0000};

  // Clip lengths in samples; a zero length disables the voice entirely
  localparam logic [NVOICE-1:0][15:0] LEN  = {16'd0, 16'd2048, 16'd1024, 16'd1024};

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/pcm_tick_gen.sv
// Free-running sample-rate divider: raises tick for one CLKSYS cycle out of
// every SAMPLE_DIV, in the last count of each period.
module pcm_tick_gen #(
  parameter int SAMPLE_DIV = 4000
) (
  input  logic CLKSYS,
  input  logic RESET,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count;

  // Count 0..SAMPLE_DIV-1 and wrap; restarts from zero whenever RESET is seen
  always_ff @(posedge CLKSYS or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/pcm_sched.sv
// Shares one 8-bit PCM sample ROM among four trigger-driven voices: latches
// trigger edges as pending requests, plays one clip at a time with
// lower-index-wins preemption, and issues one ROM read per sample tick.
module pcm_sched
  import pcm_pkg::*;
#(
  parameter int SAMPLE_DIV = 4000,
  parameter int AW         = AW_DEFAULT
) (
  input  logic              CLKSYS,
  input  logic              RESET,
  input  logic [NVOICE-1:0] trig,
  output logic [AW-1:0]     rom_addr,
  output logic              rom_rd,
  input  logic [7:0]        rom_data,
  output logic [7:0]        unsigned_audio,
  output logic              busy,
  output logic [1:0]        voice
);

  logic              tick;
  state_t            state;
  logic [AW-1:0]     addr;
  logic [AW:0]       remain;
  logic [NVOICE-1:0] pending;
  logic [NVOICE-1:0] trig_s;
  logic [NVOICE-1:0] trig_d;
  logic [NVOICE-1:0] trig_edge;
  logic [NVOICE-1:0] enable_mask;
  logic [NVOICE-1:0] clear_mask;
  logic              primed;
  logic [1:0]        cand;
  logic              cand_valid;
  logic              start_now;

  pcm_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick_gen (
    .CLKSYS(CLKSYS),
    .RESET (RESET),
    .tick  (tick)
  );

  // Voices with a zero-length clip never accept triggers
  always_comb begin
    enable_mask = '0;
    for (int i = 0; i < NVOICE; i++) begin
      enable_mask[i] = (LEN[i] != 16'd0);
    end
  end

  // Register trig, then compare against its previous value; the first cycle
  // after reset preloads both stages so a level already high is not an edge
  always_ff @(posedge CLKSYS or posedge RESET) begin
    if (RESET) begin
      trig_s <= '0;
      trig_d <= '0;
      primed <= 1'b0;
    end else if (!primed) begin
      trig_s <= trig;
      trig_d <= trig;
      primed <= 1'b1;
    end else begin
      trig_s <= trig;
      trig_d <= trig_s;
    end
  end

  assign trig_edge = trig_s & ~trig_d & enable_mask;

  // Lowest-index pending request is the candidate
  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    for (int i = NVOICE - 1; i >= 0; i--) begin
      if (pending[i]) begin
        cand       = 2'(i);
        cand_valid = 1'b1;
      end
    end
  end

  // A clip starts on a tick when idle, when the candidate outranks or equals
  // the current voice, or when the current clip has just run out
  always_comb begin
    start_now = 1'b0;
    if (tick && cand_valid) begin
      case (state)
        IDLE:    start_now = 1'b1;
        HOLD:    start_now = (cand <= voice) || (remain == '0);
        default: start_now = 1'b0;
      endcase
    end
    clear_mask = start_now ? ({{(NVOICE-1){1'b0}}, 1'b1} << cand) : '0;
  end

  // New edges set pending bits; a started voice clears its bit unless a
  // fresh edge on that same voice arrives in the same cycle
  always_ff @(posedge CLKSYS or posedge RESET) begin
    if (RESET) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clear_mask) | trig_edge;
    end
  end

  // Playback FSM: one ROM fetch per tick, sample latched the cycle after the
  // read strobe, then hold until the next tick decides continue/start/stop
  always_ff @(posedge CLKSYS or posedge RESET) begin
    if (RESET) begin
      state          <= IDLE;
      addr           <= '0;
      remain         <= '0;
      rom_addr       <= '0;
      rom_rd         <= 1'b0;
      unsigned_audio <= 8'd0;
      busy           <= 1'b0;
      voice          <= 2'd0;
    end else begin
      rom_rd <= 1'b0;
      if (start_now) begin
        addr     <= BASE[cand][AW-1:0];
        rom_addr <= BASE[cand][AW-1:0];
        remain   <= LEN[cand][AW:0];
        voice    <= cand;
        busy     <= 1'b1;
        rom_rd   <= 1'b1;
        state    <= FETCH;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          FETCH: begin
            state <= WAIT;
          end
          WAIT: begin
            unsigned_audio <= rom_data;
            addr           <= addr + 1'b1;
            remain         <= remain - 1'b1;
            state          <= HOLD;
          end
          HOLD: begin
            if (tick) begin
              if (remain != '0) begin
                rom_rd   <= 1'b1;
                rom_addr <= addr;
                state    <= FETCH;
              end else begin
                unsigned_audio <= 8'd0;
                busy           <= 1'b0;
                voice          <= 2'd0;
                state          <= IDLE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcm_sched.sv
// Scoreboard bench for pcm_sched with a short sample period and a ROM that
// returns the low address byte. Stimulus pushes the expected ROM reads of
// each clip; a monitor pops one entry per read strobe and checks the address,
// voice, strobe phase/width/cadence and the resulting audio sample.
module tb_pcm_sched;

  localparam int DIV = 8;
  localparam int AW  = 13;

  logic          CLKSYS = 1'b0;
  logic          RESET  = 1'b1;
  logic [3:0]    trig   = 4'b0000;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [7:0]    rom_data = 8'd0;
  logic [7:0]    unsigned_audio;
  logic          busy;
  logic [1:0]    voice;

  typedef struct packed {
    logic [1:0]    v;
    logic [AW-1:0] a;
    logic          gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks       = 0;
  int   passed       = 0;
  int   samples_seen = 0;
  int   cyc          = 0;
  int   last_rd      = -1000;
  int   base         = 0;

  pcm_sched #(
    .SAMPLE_DIV(DIV),
    .AW        (AW)
  ) dut (
    .CLKSYS        (CLKSYS),
    .RESET         (RESET),
    .trig          (trig),
    .rom_addr      (rom_addr),
    .rom_rd        (rom_rd),
    .rom_data      (rom_data),
    .unsigned_audio(unsigned_audio),
    .busy          (busy),
    .voice         (voice)
  );

  // 10 ns system clock
  always #5 CLKSYS = ~CLKSYS;

  // ROM model: data is the low address byte, one cycle after the address
  always @(posedge CLKSYS) rom_data <= rom_addr[7:0];

  // Cycle counter tracking the divider phase since the last reset release
  always @(posedge CLKSYS or posedge RESET) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic applyStimulus(input logic [3:0] value);
    trig = value;
  endtask

  task automatic pushClip(input logic [1:0] v, input int clip_base, input int n, input logic gap_first);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.v   = v;
      e.a   = AW'(clip_base + i);
      e.gap = (i == 0) ? gap_first : 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic waitSamples(input int n);
    int budget = 20000;
    while (samples_seen < n && budget > 0) begin
      @(posedge CLKSYS);
      budget--;
    end
    checkOutput("sample_wait", (samples_seen >= n) ? 32'd1 : 32'd0, 32'd1);
    @(negedge CLKSYS);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_audio"}, unsigned_audio, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_voice"}, voice, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkIdle(tag);
    checkOutput({tag, "_rom_rd"}, rom_rd, 0);
    checkOutput({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  // Monitor: every read strobe consumes one scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(negedge CLKSYS);
      if (RESET) begin
        last_rd = -1000;
      end else if (rom_rd) begin
        samples_seen++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_read", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rom_addr", rom_addr, e.a);
          checkOutput("voice", voice, e.v);
          checkOutput("busy", busy, 1);
          checkOutput("rd_phase", cyc % DIV, 0);
          if (e.gap) checkOutput("rd_gap", cyc - last_rd, DIV);
          last_rd = cyc;
          @(negedge CLKSYS);
          if (!RESET) checkOutput("rd_width", rom_rd, 0);
          @(negedge CLKSYS);
          if (!RESET) checkOutput("audio", unsigned_audio, e.a[7:0]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge CLKSYS);
    checkResetState("reset");
    checkOutput("reset_pending", dut.pending, 0);
    RESET = 1'b0;
    repeat (4) @(negedge CLKSYS);

    // Idle v0 trigger: full clip, then silence from the following tick
    pushClip(2'd0, 'h0000, 1024, 1'b0);
    applyStimulus(4'b0001);
    @(negedge CLKSYS);
    applyStimulus(4'b0000);
    waitSamples(1024);
    repeat (8) @(negedge CLKSYS);
    checkIdle("v0_done");

    // v1 preempted by v0 after 10 samples; v2/v3 edges during v0
    base = samples_seen;
    pushClip(2'd1, 'h0400, 10, 1'b0);
    applyStimulus(4'b0010);
    @(negedge CLKSYS);
    applyStimulus(4'b0000);
    waitSamples(base + 10);
    pushClip(2'd0, 'h0000, 1024, 1'b1);
    applyStimulus(4'b0001);
    @(negedge CLKSYS);
    applyStimulus(4'b0000);
    waitSamples(base + 110);
    pushClip(2'd2, 'h0800, 20, 1'b1);
    applyStimulus(4'b1100);
    repeat (3) @(negedge CLKSYS);
    checkOutput("v3_pending", dut.pending[3], 0);
    checkOutput("v2_pending", dut.pending[2], 1);
    applyStimulus(4'b0000);
    waitSamples(base + 1054);
    repeat (2) @(negedge CLKSYS);
    RESET = 1'b1;
    #1;
    checkResetState("rst_v2");
    @(negedge CLKSYS);
    RESET = 1'b0;
    repeat (4) @(negedge CLKSYS);

    // v1 retriggered at sample 500 restarts its clip
    base = samples_seen;
    pushClip(2'd1, 'h0400, 500, 1'b0);
    applyStimulus(4'b0010);
    @(negedge CLKSYS);
    applyStimulus(4'b0000);
    waitSamples(base + 500);
    pushClip(2'd1, 'h0400, 1024, 1'b1);
    applyStimulus(4'b0010);
    @(negedge CLKSYS);
    applyStimulus(4'b0000);
    waitSamples(base + 1524);
    repeat (8) @(negedge CLKSYS);
    checkIdle("v1_done");

    // Simultaneous v0/v1/v2 play back-to-back; reset during v2 with trig[0] held
    base = samples_seen;
    pushClip(2'd0, 'h0000, 1024, 1'b0);
    pushClip(2'd1, 'h0400, 1024, 1'b1);
    pushClip(2'd2, 'h0800, 20, 1'b1);
    applyStimulus(4'b0111);
    @(negedge CLKSYS);
    applyStimulus(4'b0001);
    waitSamples(base + 2068);
    repeat (2) @(negedge CLKSYS);
    RESET = 1'b1;
    #1;
    checkResetState("rst_chain");
    repeat (2) @(negedge CLKSYS);
    RESET = 1'b0;
    repeat (60) @(negedge CLKSYS);
    checkIdle("held_trig");
    checkOutput("held_pending", dut.pending, 0);

    // A fresh edge after the held level starts v0 again
    base = samples_seen;
    applyStimulus(4'b0000);
    repeat (2) @(negedge CLKSYS);
    pushClip(2'd0, 'h0000, 5, 1'b0);
    applyStimulus(4'b0001);
    @(negedge CLKSYS);
    applyStimulus(4'b0000);
    waitSamples(base + 5);
    repeat (2) @(negedge CLKSYS);
    RESET = 1'b1;
    #1;
    checkResetState("rst_final");
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
